// File: rtl/issue_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : issue_scheduler_if
// Description : Dispatch, writeback-broadcast, flush and issue signals of the
//               issue scheduler. The master drives dispatch/wakeup/FU-ready,
//               the slave (scheduler) drives readiness, issue and free count.
// Revision    : 1.0 - initial release
// ============================================================================
interface issue_scheduler_if;
    // dispatch slots
    logic       disp_valid_0, disp_valid_1;
    logic [1:0] disp_fu_0,    disp_fu_1;
    logic [5:0] disp_ps1_0,   disp_ps1_1;
    logic [5:0] disp_ps2_0,   disp_ps2_1;
    logic [5:0] disp_pd_0,    disp_pd_1;
    logic       disp_rdy1_0,  disp_rdy1_1;
    logic       disp_rdy2_0,  disp_rdy2_1;
    logic [3:0] disp_rob_0,   disp_rob_1;
    logic       disp_ready;
    // completion broadcast
    logic       wb_valid_0,   wb_valid_1;
    logic [5:0] wb_tag_0,     wb_tag_1;
    // squash
    logic       flush;
    // issue ports, one per functional unit
    logic       iss_valid_0,  iss_valid_1,  iss_valid_2;
    logic       iss_ready_0,  iss_ready_1,  iss_ready_2;
    logic [5:0] iss_ps1_0,    iss_ps1_1,    iss_ps1_2;
    logic [5:0] iss_ps2_0,    iss_ps2_1,    iss_ps2_2;
    logic [5:0] iss_pd_0,     iss_pd_1,     iss_pd_2;
    logic [3:0] iss_rob_0,    iss_rob_1,    iss_rob_2;
    logic [4:0] free_cnt;

    modport master (
        output disp_valid_0, disp_valid_1, disp_fu_0, disp_fu_1,
               disp_ps1_0, disp_ps1_1, disp_ps2_0, disp_ps2_1,
               disp_pd_0, disp_pd_1, disp_rdy1_0, disp_rdy1_1,
               disp_rdy2_0, disp_rdy2_1, disp_rob_0, disp_rob_1,
               wb_valid_0, wb_valid_1, wb_tag_0, wb_tag_1, flush,
               iss_ready_0, iss_ready_1, iss_ready_2,
        input  disp_ready, free_cnt,
               iss_valid_0, iss_valid_1, iss_valid_2,
               iss_ps1_0, iss_ps1_1, iss_ps1_2,
               iss_ps2_0, iss_ps2_1, iss_ps2_2,
               iss_pd_0, iss_pd_1, iss_pd_2,
               iss_rob_0, iss_rob_1, iss_rob_2
    );

    modport slave (
        input  disp_valid_0, disp_valid_1, disp_fu_0, disp_fu_1,
               disp_ps1_0, disp_ps1_1, disp_ps2_0, disp_ps2_1,
               disp_pd_0, disp_pd_1, disp_rdy1_0, disp_rdy1_1,
               disp_rdy2_0, disp_rdy2_1, disp_rob_0, disp_rob_1,
               wb_valid_0, wb_valid_1, wb_tag_0, wb_tag_1, flush,
               iss_ready_0, iss_ready_1, iss_ready_2,
        output disp_ready, free_cnt,
               iss_valid_0, iss_valid_1, iss_valid_2,
               iss_ps1_0, iss_ps1_1, iss_ps1_2,
               iss_ps2_0, iss_ps2_1, iss_ps2_2,
               iss_pd_0, iss_pd_1, iss_pd_2,
               iss_rob_0, iss_rob_1, iss_rob_2
    );
endinterface
`default_nettype wire

// File: rtl/issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : issue_scheduler
// Description : 16-entry unified issue queue. Two-wide dispatch into the
//               lowest free entries, tag-broadcast wakeup, age-matrix
//               oldest-first select per FU (ALU0, ALU1, MEM) and one
//               skid-free issue register per FU with valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_scheduler (
    input  logic                clk,
    input  logic                rst_n,
    issue_scheduler_if.slave    bus
);

    localparam int c_NUM_ENT = 16;
    localparam int c_NUM_FU  = 3;

    // ---------------- entry storage ----------------
    logic [15:0] r_valid;
    logic [1:0]  r_fu   [c_NUM_ENT];
    logic [5:0]  r_ps1  [c_NUM_ENT];
    logic [5:0]  r_ps2  [c_NUM_ENT];
    logic [5:0]  r_pd   [c_NUM_ENT];
    logic [3:0]  r_rob  [c_NUM_ENT];
    logic [15:0] r_rdy1;
    logic [15:0] r_rdy2;
    // r_older[i][j] = 1 : entry i was written before entry j
    logic [15:0] r_older [c_NUM_ENT];

    // ---------------- issue registers ----------------
    logic [2:0]  r_iss_valid;
    logic [5:0]  r_iss_ps1 [c_NUM_FU];
    logic [5:0]  r_iss_ps2 [c_NUM_FU];
    logic [5:0]  r_iss_pd  [c_NUM_FU];
    logic [3:0]  r_iss_rob [c_NUM_FU];

    // ---------------- unpacked interface inputs ----------------
    logic        w_dv    [2];
    logic [1:0]  w_dfu   [2];
    logic [5:0]  w_dps1  [2];
    logic [5:0]  w_dps2  [2];
    logic [5:0]  w_dpd   [2];
    logic        w_drdy1 [2];
    logic        w_drdy2 [2];
    logic [3:0]  w_drob  [2];
    logic [1:0]  w_nfu   [2];
    logic        w_nrdy1 [2];
    logic        w_nrdy2 [2];
    logic        w_wbv   [2];
    logic [5:0]  w_wbt   [2];
    logic        w_flush;
    logic [2:0]  w_iss_ready;

    assign w_dv[0]    = bus.disp_valid_0;
    assign w_dv[1]    = bus.disp_valid_1;
    assign w_dfu[0]   = bus.disp_fu_0;
    assign w_dfu[1]   = bus.disp_fu_1;
    assign w_dps1[0]  = bus.disp_ps1_0;
    assign w_dps1[1]  = bus.disp_ps1_1;
    assign w_dps2[0]  = bus.disp_ps2_0;
    assign w_dps2[1]  = bus.disp_ps2_1;
    assign w_dpd[0]   = bus.disp_pd_0;
    assign w_dpd[1]   = bus.disp_pd_1;
    assign w_drdy1[0] = bus.disp_rdy1_0;
    assign w_drdy1[1] = bus.disp_rdy1_1;
    assign w_drdy2[0] = bus.disp_rdy2_0;
    assign w_drdy2[1] = bus.disp_rdy2_1;
    assign w_drob[0]  = bus.disp_rob_0;
    assign w_drob[1]  = bus.disp_rob_1;
    assign w_wbv[0]   = bus.wb_valid_0;
    assign w_wbv[1]   = bus.wb_valid_1;
    assign w_wbt[0]   = bus.wb_tag_0;
    assign w_wbt[1]   = bus.wb_tag_1;
    assign w_flush    = bus.flush;
    assign w_iss_ready = {bus.iss_ready_2, bus.iss_ready_1, bus.iss_ready_0};

    // Per-slot normalisation: FU code 3 folds onto MEM; tag 0 and any
    // same-cycle writeback of a source tag make that source ready on entry.
    generate
        for (genvar k = 0; k < 2; k++) begin : g_slot
            assign w_nfu[k]   = (w_dfu[k] == 2'd3) ? 2'd2 : w_dfu[k];
            assign w_nrdy1[k] = w_drdy1[k] || (w_dps1[k] == 6'd0) ||
                                (w_wbv[0] && (w_wbt[0] == w_dps1[k])) ||
                                (w_wbv[1] && (w_wbt[1] == w_dps1[k]));
            assign w_nrdy2[k] = w_drdy2[k] || (w_dps2[k] == 6'd0) ||
                                (w_wbv[0] && (w_wbt[0] == w_dps2[k])) ||
                                (w_wbv[1] && (w_wbt[1] == w_dps2[k]));
        end
    endgenerate

    // ---------------- occupancy ----------------
    logic [4:0] w_valid_cnt;
    logic [4:0] w_free_cnt;
    logic       w_disp_ready;

    // Count resident entries; freeing only shows after the edge that clears valid.
    always_comb begin
        w_valid_cnt = 5'd0;
        for (int i = 0; i < c_NUM_ENT; i++) begin
            w_valid_cnt = w_valid_cnt + 5'(r_valid[i]);
        end
    end

    assign w_free_cnt   = 5'd16 - w_valid_cnt;
    assign w_disp_ready = (w_free_cnt >= 5'd2);

    // ---------------- allocation ----------------
    logic [3:0] w_a0;
    logic [3:0] w_a1;
    logic [3:0] w_tgt0;
    logic [3:0] w_tgt1;
    logic       w_we0;
    logic       w_we1;

    // Find the lowest and second-lowest free entry indices.
    always_comb begin
        w_a0 = 4'd0;
        w_a1 = 4'd0;
        for (int i = c_NUM_ENT - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_a0 = 4'(i);
        end
        for (int i = c_NUM_ENT - 1; i >= 0; i--) begin
            if (!r_valid[i] && (4'(i) != w_a0)) w_a1 = 4'(i);
        end
    end

    // A lone slot-1 instruction takes the lowest free entry.
    assign w_we0  = !w_flush && w_disp_ready && w_dv[0];
    assign w_we1  = !w_flush && w_disp_ready && w_dv[1];
    assign w_tgt0 = w_a0;
    assign w_tgt1 = w_dv[0] ? w_a1 : w_a0;

    // ---------------- select ----------------
    logic [15:0] w_elig [c_NUM_FU];
    logic [15:0] w_sel  [c_NUM_FU];
    logic        w_blk;
    logic [2:0]  w_any;
    logic [2:0]  w_load;
    logic [5:0]  w_sel_ps1 [c_NUM_FU];
    logic [5:0]  w_sel_ps2 [c_NUM_FU];
    logic [5:0]  w_sel_pd  [c_NUM_FU];
    logic [3:0]  w_sel_rob [c_NUM_FU];
    logic [15:0] w_free_mask;

    // Eligibility uses only registered ready bits, so wakeup selects a cycle later.
    always_comb begin
        for (int f = 0; f < c_NUM_FU; f++) begin
            for (int i = 0; i < c_NUM_ENT; i++) begin
                w_elig[f][i] = r_valid[i] && (r_fu[i] == 2'(f)) && r_rdy1[i] && r_rdy2[i];
            end
        end
    end

    // Oldest-first: an eligible entry wins if no other eligible entry is older.
    always_comb begin
        w_blk = 1'b0;
        for (int f = 0; f < c_NUM_FU; f++) begin
            for (int i = 0; i < c_NUM_ENT; i++) begin
                w_blk = 1'b0;
                for (int j = 0; j < c_NUM_ENT; j++) begin
                    if ((j != i) && w_elig[f][j] && r_older[j][i]) w_blk = 1'b1;
                end
                w_sel[f][i] = w_elig[f][i] && !w_blk;
            end
        end
    end

    // Handshake gating per FU and one-hot payload mux of the winner.
    always_comb begin
        for (int f = 0; f < c_NUM_FU; f++) begin
            w_any[f]     = |w_sel[f];
            w_load[f]    = w_any[f] && (!r_iss_valid[f] || w_iss_ready[f]);
            w_sel_ps1[f] = 6'd0;
            w_sel_ps2[f] = 6'd0;
            w_sel_pd[f]  = 6'd0;
            w_sel_rob[f] = 4'd0;
            for (int i = 0; i < c_NUM_ENT; i++) begin
                if (w_sel[f][i]) begin
                    w_sel_ps1[f] = r_ps1[i];
                    w_sel_ps2[f] = r_ps2[i];
                    w_sel_pd[f]  = r_pd[i];
                    w_sel_rob[f] = r_rob[i];
                end
            end
        end
    end

    // Entries that move into an issue register leave the queue at that edge.
    always_comb begin
        w_free_mask = 16'd0;
        for (int f = 0; f < c_NUM_FU; f++) begin
            for (int i = 0; i < c_NUM_ENT; i++) begin
                if (w_load[f] && w_sel[f][i]) w_free_mask[i] = 1'b1;
            end
        end
    end

    // Entry state: allocate, free on issue, wake sources on writeback broadcast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 16'd0;
            r_rdy1  <= 16'd0;
            r_rdy2  <= 16'd0;
            for (int i = 0; i < c_NUM_ENT; i++) begin
                r_fu[i]  <= 2'd0;
                r_ps1[i] <= 6'd0;
                r_ps2[i] <= 6'd0;
                r_pd[i]  <= 6'd0;
                r_rob[i] <= 4'd0;
            end
        end else if (w_flush) begin
            r_valid <= 16'd0;
        end else begin
            for (int i = 0; i < c_NUM_ENT; i++) begin
                if (w_we0 && (w_tgt0 == 4'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_fu[i]    <= w_nfu[0];
                    r_ps1[i]   <= w_dps1[0];
                    r_ps2[i]   <= w_dps2[0];
                    r_pd[i]    <= w_dpd[0];
                    r_rob[i]   <= w_drob[0];
                    r_rdy1[i]  <= w_nrdy1[0];
                    r_rdy2[i]  <= w_nrdy2[0];
                end else if (w_we1 && (w_tgt1 == 4'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_fu[i]    <= w_nfu[1];
                    r_ps1[i]   <= w_dps1[1];
                    r_ps2[i]   <= w_dps2[1];
                    r_pd[i]    <= w_dpd[1];
                    r_rob[i]   <= w_drob[1];
                    r_rdy1[i]  <= w_nrdy1[1];
                    r_rdy2[i]  <= w_nrdy2[1];
                end else begin
                    if (w_free_mask[i]) r_valid[i] <= 1'b0;
                    if ((w_wbv[0] && (w_wbt[0] == r_ps1[i])) ||
                        (w_wbv[1] && (w_wbt[1] == r_ps1[i]))) r_rdy1[i] <= 1'b1;
                    if ((w_wbv[0] && (w_wbt[0] == r_ps2[i])) ||
                        (w_wbv[1] && (w_wbt[1] == r_ps2[i]))) r_rdy2[i] <= 1'b1;
                end
            end
        end
    end

    // Age matrix: a new entry's row is cleared (older than nothing) and its
    // column set (everyone else is older); slot 0 is made older than slot 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_NUM_ENT; i++) r_older[i] <= 16'd0;
        end else if (w_flush) begin
            for (int i = 0; i < c_NUM_ENT; i++) r_older[i] <= 16'd0;
        end else begin
            for (int i = 0; i < c_NUM_ENT; i++) begin
                for (int j = 0; j < c_NUM_ENT; j++) begin
                    if (w_we0 && (w_tgt0 == 4'(i))) begin
                        r_older[i][j] <= w_we1 && (w_tgt1 == 4'(j));
                    end else if (w_we1 && (w_tgt1 == 4'(i))) begin
                        r_older[i][j] <= 1'b0;
                    end else if ((w_we0 && (w_tgt0 == 4'(j))) ||
                                 (w_we1 && (w_tgt1 == 4'(j)))) begin
                        r_older[i][j] <= 1'b1;
                    end
                end
            end
        end
    end

    // Issue registers: load on empty or accepted, hold while stalled, drain otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iss_valid <= 3'd0;
            for (int f = 0; f < c_NUM_FU; f++) begin
                r_iss_ps1[f] <= 6'd0;
                r_iss_ps2[f] <= 6'd0;
                r_iss_pd[f]  <= 6'd0;
                r_iss_rob[f] <= 4'd0;
            end
        end else if (w_flush) begin
            r_iss_valid <= 3'd0;
        end else begin
            for (int f = 0; f < c_NUM_FU; f++) begin
                if (w_load[f]) begin
                    r_iss_valid[f] <= 1'b1;
                    r_iss_ps1[f]   <= w_sel_ps1[f];
                    r_iss_ps2[f]   <= w_sel_ps2[f];
                    r_iss_pd[f]    <= w_sel_pd[f];
                    r_iss_rob[f]   <= w_sel_rob[f];
                end else if (w_iss_ready[f]) begin
                    r_iss_valid[f] <= 1'b0;
                end
            end
        end
    end

    // ---------------- outputs ----------------
    assign bus.disp_ready  = w_disp_ready;
    assign bus.free_cnt    = w_free_cnt;
    assign bus.iss_valid_0 = r_iss_valid[0];
    assign bus.iss_valid_1 = r_iss_valid[1];
    assign bus.iss_valid_2 = r_iss_valid[2];
    assign bus.iss_ps1_0   = r_iss_ps1[0];
    assign bus.iss_ps1_1   = r_iss_ps1[1];
    assign bus.iss_ps1_2   = r_iss_ps1[2];
    assign bus.iss_ps2_0   = r_iss_ps2[0];
    assign bus.iss_ps2_1   = r_iss_ps2[1];
    assign bus.iss_ps2_2   = r_iss_ps2[2];
    assign bus.iss_pd_0    = r_iss_pd[0];
    assign bus.iss_pd_1    = r_iss_pd[1];
    assign bus.iss_pd_2    = r_iss_pd[2];
    assign bus.iss_rob_0   = r_iss_rob[0];
    assign bus.iss_rob_1   = r_iss_rob[1];
    assign bus.iss_rob_2   = r_iss_rob[2];

endmodule
`default_nettype wire

// File: tb/tb_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_scheduler
// Description : Directed self-checking bench for issue_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_scheduler;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    issue_scheduler_if bus ();

    issue_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.disp_valid_0 = 0; bus.disp_valid_1 = 0;
        bus.disp_fu_0 = 0;    bus.disp_fu_1 = 0;
        bus.disp_ps1_0 = 0;   bus.disp_ps1_1 = 0;
        bus.disp_ps2_0 = 0;   bus.disp_ps2_1 = 0;
        bus.disp_pd_0 = 0;    bus.disp_pd_1 = 0;
        bus.disp_rdy1_0 = 0;  bus.disp_rdy1_1 = 0;
        bus.disp_rdy2_0 = 0;  bus.disp_rdy2_1 = 0;
        bus.disp_rob_0 = 0;   bus.disp_rob_1 = 0;
        bus.wb_valid_0 = 0;   bus.wb_valid_1 = 0;
        bus.wb_tag_0 = 0;     bus.wb_tag_1 = 0;
        bus.flush = 0;
    endtask

    task automatic set_slot(input int k, input logic [1:0] fu, input logic [5:0] p1,
                            input logic [5:0] p2, input logic [5:0] pd,
                            input logic r1, input logic r2, input logic [3:0] rob);
        if (k == 0) begin
            bus.disp_valid_0 = 1; bus.disp_fu_0 = fu; bus.disp_ps1_0 = p1;
            bus.disp_ps2_0 = p2;  bus.disp_pd_0 = pd; bus.disp_rdy1_0 = r1;
            bus.disp_rdy2_0 = r2; bus.disp_rob_0 = rob;
        end else begin
            bus.disp_valid_1 = 1; bus.disp_fu_1 = fu; bus.disp_ps1_1 = p1;
            bus.disp_ps2_1 = p2;  bus.disp_pd_1 = pd; bus.disp_rdy1_1 = r1;
            bus.disp_rdy2_1 = r2; bus.disp_rob_1 = rob;
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 0;
        clear_in();
        bus.iss_ready_0 = 1; bus.iss_ready_1 = 1; bus.iss_ready_2 = 1;

        // ---- reset state ----
        #2;
        chk("rst_free_cnt",   bus.free_cnt, 16);
        chk("rst_disp_ready", bus.disp_ready, 1);
        chk("rst_iss_valid",  {bus.iss_valid_2, bus.iss_valid_1, bus.iss_valid_0}, 0);
        chk("rst_iss_pd0",    bus.iss_pd_0, 0);
        #10 rst_n = 1;
        tick();

        // ---- two ready ALU ops, one-cycle issue latency ----
        set_slot(0, 2'd0, 6'd3, 6'd4, 6'd5, 1, 1, 4'd1);
        set_slot(1, 2'd1, 6'd3, 6'd4, 6'd6, 1, 1, 4'd2);
        tick();
        clear_in();
        chk("alu_free_after_disp", bus.free_cnt, 14);
        chk("alu_no_early_issue",  bus.iss_valid_0, 0);
        tick();
        chk("alu_iss_valid0", bus.iss_valid_0, 1);
        chk("alu_iss_pd0",    bus.iss_pd_0, 5);
        chk("alu_iss_rob0",   bus.iss_rob_0, 1);
        chk("alu_iss_valid1", bus.iss_valid_1, 1);
        chk("alu_iss_pd1",    bus.iss_pd_1, 6);
        chk("alu_free_back",  bus.free_cnt, 16);
        tick();
        chk("alu_drain0", bus.iss_valid_0, 0);

        // ---- wakeup by writeback, issue one cycle after the wb edge ----
        set_slot(0, 2'd0, 6'd7, 6'd0, 6'd8, 0, 0, 4'd3);
        tick();
        clear_in();
        chk("wk_free", bus.free_cnt, 15);
        tick();
        chk("wk_wait", bus.iss_valid_0, 0);
        bus.wb_valid_0 = 1; bus.wb_tag_0 = 6'd7;
        tick();
        clear_in();
        chk("wk_not_at_wb_edge", bus.iss_valid_0, 0);
        tick();
        chk("wk_issue_valid", bus.iss_valid_0, 1);
        chk("wk_issue_pd",    bus.iss_pd_0, 8);
        chk("wk_issue_ps1",   bus.iss_ps1_0, 7);
        tick();

        // ---- same-cycle writeback during dispatch ----
        set_slot(0, 2'd0, 6'd9, 6'd0, 6'd13, 0, 1, 4'd4);
        bus.wb_valid_1 = 1; bus.wb_tag_1 = 6'd9;
        tick();
        clear_in();
        chk("bypass_free", bus.free_cnt, 15);
        tick();
        chk("bypass_valid", bus.iss_valid_0, 1);
        chk("bypass_pd",    bus.iss_pd_0, 13);
        tick();

        // ---- MEM stall then oldest-first drain (fu code 3 folds onto MEM) ----
        bus.iss_ready_2 = 0;
        set_slot(0, 2'd2, 6'd1, 6'd2, 6'd10, 1, 1, 4'd5);
        set_slot(1, 2'd3, 6'd1, 6'd2, 6'd11, 1, 1, 4'd6);
        tick();
        clear_in();
        set_slot(0, 2'd2, 6'd1, 6'd2, 6'd12, 1, 1, 4'd7);
        tick();
        clear_in();
        chk("mem_first_valid", bus.iss_valid_2, 1);
        chk("mem_first_pd",    bus.iss_pd_2, 10);
        chk("mem_free",        bus.free_cnt, 14);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("mem_stall_valid", bus.iss_valid_2, 1);
            chk("mem_stall_pd",    bus.iss_pd_2, 10);
            chk("mem_stall_rob",   bus.iss_rob_2, 5);
        end
        bus.iss_ready_2 = 1;
        tick();
        chk("mem_second_pd", bus.iss_pd_2, 11);
        tick();
        chk("mem_third_pd",    bus.iss_pd_2, 12);
        chk("mem_third_valid", bus.iss_valid_2, 1);
        tick();
        chk("mem_drained", bus.iss_valid_2, 0);
        chk("mem_free_end", bus.free_cnt, 16);

        // ---- fill all 16 entries with unready MEM ops ----
        for (int p = 0; p < 8; p++) begin
            set_slot(0, 2'd2, (p == 0) ? 6'd21 : 6'd20, 6'd0, 6'(32 + 2 * p), 0, 0, 4'(p));
            set_slot(1, 2'd2, 6'd20, 6'd0, 6'(33 + 2 * p), 0, 0, 4'(p));
            tick();
            clear_in();
            if (p == 6) begin
                chk("fill_free2",  bus.free_cnt, 2);
                chk("fill_ready2", bus.disp_ready, 1);
            end
        end
        chk("fill_free0",  bus.free_cnt, 0);
        chk("fill_ready0", bus.disp_ready, 0);
        set_slot(0, 2'd0, 6'd0, 6'd0, 6'd50, 1, 1, 4'd8);
        set_slot(1, 2'd0, 6'd0, 6'd0, 6'd51, 1, 1, 4'd9);
        tick();
        clear_in();
        chk("full_ignored_free", bus.free_cnt, 0);
        bus.wb_valid_0 = 1; bus.wb_tag_0 = 6'd21;
        tick();
        clear_in();
        chk("full_no_alu_issue", bus.iss_valid_0, 0);
        tick();
        chk("one_free_cnt",   bus.free_cnt, 1);
        chk("one_free_ready", bus.disp_ready, 0);
        chk("one_free_iss2",  bus.iss_valid_2, 1);
        chk("one_free_pd2",   bus.iss_pd_2, 32);
        set_slot(0, 2'd0, 6'd0, 6'd0, 6'd52, 1, 1, 4'd10);
        tick();
        clear_in();
        chk("one_free_ignored", bus.free_cnt, 1);
        tick();
        chk("one_free_no_iss0", bus.iss_valid_0, 0);
        bus.flush = 1;
        tick();
        clear_in();
        chk("fill_flush_free", bus.free_cnt, 16);

        // ---- flush with 5 resident entries and a held ALU0 issue ----
        bus.iss_ready_0 = 0;
        set_slot(0, 2'd0, 6'd1, 6'd2, 6'd30, 1, 1, 4'd1);
        set_slot(1, 2'd1, 6'd40, 6'd0, 6'd41, 0, 0, 4'd2);
        tick();
        clear_in();
        set_slot(0, 2'd1, 6'd40, 6'd0, 6'd42, 0, 0, 4'd3);
        set_slot(1, 2'd1, 6'd40, 6'd0, 6'd43, 0, 0, 4'd4);
        tick();
        clear_in();
        set_slot(0, 2'd1, 6'd40, 6'd0, 6'd44, 0, 0, 4'd5);
        set_slot(1, 2'd1, 6'd40, 6'd0, 6'd45, 0, 0, 4'd6);
        tick();
        clear_in();
        chk("pre_flush_free",  bus.free_cnt, 11);
        chk("pre_flush_iss0",  bus.iss_valid_0, 1);
        chk("pre_flush_pd0",   bus.iss_pd_0, 30);
        bus.flush = 1;
        set_slot(0, 2'd0, 6'd0, 6'd0, 6'd60, 1, 1, 4'd7);
        set_slot(1, 2'd0, 6'd0, 6'd0, 6'd61, 1, 1, 4'd8);
        tick();
        clear_in();
        chk("flush_free",  bus.free_cnt, 16);
        chk("flush_iss",   {bus.iss_valid_2, bus.iss_valid_1, bus.iss_valid_0}, 0);
        chk("flush_ready", bus.disp_ready, 1);
        tick();
        chk("flush_disp_dropped", bus.iss_valid_0, 0);
        chk("flush_free_after",   bus.free_cnt, 16);

        // ---- asynchronous reset pulse mid-stream ----
        set_slot(0, 2'd0, 6'd1, 6'd2, 6'd45, 1, 1, 4'd7);
        set_slot(1, 2'd0, 6'd50, 6'd0, 6'd46, 0, 0, 4'd8);
        tick();
        clear_in();
        tick();
        chk("pre_rst_iss0", bus.iss_valid_0, 1);
        chk("pre_rst_free", bus.free_cnt, 15);
        #3;
        rst_n = 0;
        #1;
        chk("arst_iss0",  bus.iss_valid_0, 0);
        chk("arst_pd0",   bus.iss_pd_0, 0);
        chk("arst_rob0",  bus.iss_rob_0, 0);
        chk("arst_free",  bus.free_cnt, 16);
        chk("arst_ready", bus.disp_ready, 1);
        rst_n = 1;
        #1;
        chk("arst_free_released", bus.free_cnt, 16);
        bus.iss_ready_0 = 1;
        tick();
        bus.wb_valid_0 = 1; bus.wb_tag_0 = 6'd50;
        tick();
        clear_in();
        tick();
        chk("post_rst_no_issue", bus.iss_valid_0, 0);
        tick();
        chk("post_rst_no_issue2", bus.iss_valid_0, 0);
        chk("post_rst_free",      bus.free_cnt, 16);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
